rvh_pmp_checker: RTL

//  Sequences PMP permission checks for one requester (LSU or IFU) over a bank of PMP entries.

---
 rtl/rvh_pmp_checker.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rvh_pmp_checker.sv
// Two-phase PMP permission sequencer: checks the first and last byte of an access against the entry bank.
// Optional feature macro RVH_PMP_CHK_ALIGN_EN: misaligned requests fault at once without an entry check.
module rvh_pmp_checker #(
  parameter int unsigned PMP_ENTRY_NUM = 16,
  parameter int unsigned TAG_W         = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_vld_i,
  output logic                     req_rdy_o,
  input  logic [55:0]              req_paddr_i,
  input  logic [1:0]               req_size_i,
  input  logic [1:0]               req_access_type_i,
  input  logic                     req_priv_m_i,
  input  logic [TAG_W-1:0]         req_tag_i,
  output logic                     chk_vld_o,
  output logic [55:0]              chk_paddr_o,
  output logic [1:0]               chk_access_type_o,
  input  logic [PMP_ENTRY_NUM-1:0] entry_match_i,
  input  logic [PMP_ENTRY_NUM-1:0] entry_fail_i,
  input  logic [PMP_ENTRY_NUM-1:0] entry_lock_i,
  input  logic [PMP_ENTRY_NUM-1:0] entry_active_i,
  output logic                     resp_vld_o,
  input  logic                     resp_rdy_i,
  output logic                     resp_fault_o,
  output logic [TAG_W-1:0]         resp_tag_o
);

  localparam int unsigned PA_W  = 56;
  localparam int unsigned IDX_W = (PMP_ENTRY_NUM > 1) ? $clog2(PMP_ENTRY_NUM) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHK_LO = 2'd1;
  localparam logic [1:0] CHK_HI = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PA_W-1:0]  paddr_q, paddr_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       type_q, type_d;
  logic             priv_q, priv_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             lo_hit_q, lo_hit_d;
  logic             lo_fault_q, lo_fault_d;
  logic [IDX_W-1:0] lo_idx_q, lo_idx_d;
  logic             req_rdy_q, req_rdy_d;
  logic             chk_vld_q, chk_vld_d;
  logic [PA_W-1:0]  chk_paddr_q, chk_paddr_d;
  logic             resp_vld_q, resp_vld_d;
  logic             fault_q, fault_d;

  logic             cur_hit;
  logic             cur_fault;
  logic [IDX_W-1:0] cur_idx;
  logic [PA_W-1:0]  hi_paddr;

`ifdef RVH_PMP_CHK_ALIGN_EN
  logic misaligned;
  always_comb misaligned = |(req_paddr_i[2:0] & 3'((4'd1 << req_size_i) - 4'd1));
`endif

  // Last byte of the access; a carry out of the top bit simply wraps.
  always_comb hi_paddr = paddr_q + ((PA_W'(1) << size_q) - PA_W'(1));

  // Per-phase verdict from the entry outputs of this cycle; lowest matching index wins.
  always_comb begin
    cur_idx = '0;
    for (int i = int'(PMP_ENTRY_NUM) - 1; i >= 0; i--) begin
      if (entry_match_i[i]) cur_idx = IDX_W'(i);
    end
    cur_hit   = |entry_match_i;
    cur_fault = cur_hit ? (entry_fail_i[cur_idx] & (~priv_q | entry_lock_i[cur_idx]))
                        : (~priv_q & (|entry_active_i));
    if (type_q == 2'd3) cur_fault = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    size_d      = size_q;
    type_d      = type_q;
    priv_d      = priv_q;
    tag_d       = tag_q;
    lo_hit_d    = lo_hit_q;
    lo_fault_d  = lo_fault_q;
    lo_idx_d    = lo_idx_q;
    req_rdy_d   = req_rdy_q;
    chk_vld_d   = chk_vld_q;
    chk_paddr_d = chk_paddr_q;
    resp_vld_d  = resp_vld_q;
    fault_d     = fault_q;
    case (state_q)
      IDLE: begin
        if (req_vld_i) begin
          paddr_d     = req_paddr_i;
          size_d      = req_size_i;
          type_d      = req_access_type_i;
          priv_d      = req_priv_m_i;
          tag_d       = req_tag_i;
          req_rdy_d   = 1'b0;
          chk_vld_d   = 1'b1;
          chk_paddr_d = req_paddr_i;
          state_d     = CHK_LO;
`ifdef RVH_PMP_CHK_ALIGN_EN
          if (misaligned) begin
            chk_vld_d  = 1'b0;
            resp_vld_d = 1'b1;
            fault_d    = 1'b1;
            state_d    = RESP;
          end
`endif
        end
      end
      CHK_LO: begin
        lo_hit_d   = cur_hit;
        lo_fault_d = cur_fault;
        lo_idx_d   = cur_idx;
        if (size_q != 2'd0) begin
          chk_paddr_d = hi_paddr;
          state_d     = CHK_HI;
        end else begin
          chk_vld_d  = 1'b0;
          resp_vld_d = 1'b1;
          fault_d    = cur_fault;
          state_d    = RESP;
        end
      end
      CHK_HI: begin
        chk_vld_d  = 1'b0;
        resp_vld_d = 1'b1;
        fault_d    = lo_fault_q | cur_fault | (lo_hit_q != cur_hit)
                   | (lo_hit_q & cur_hit & (lo_idx_q != cur_idx));
        state_d    = RESP;
      end
      default: begin
        if (resp_rdy_i) begin
          resp_vld_d = 1'b0;
          req_rdy_d  = 1'b1;
          state_d    = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      size_q      <= '0;
      type_q      <= '0;
      priv_q      <= 1'b0;
      tag_q       <= '0;
      lo_hit_q    <= 1'b0;
      lo_fault_q  <= 1'b0;
      lo_idx_q    <= '0;
      req_rdy_q   <= 1'b1;
      chk_vld_q   <= 1'b0;
      chk_paddr_q <= '0;
      resp_vld_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      size_q      <= size_d;
      type_q      <= type_d;
      priv_q      <= priv_d;
      tag_q       <= tag_d;
      lo_hit_q    <= lo_hit_d;
      lo_fault_q  <= lo_fault_d;
      lo_idx_q    <= lo_idx_d;
      req_rdy_q   <= req_rdy_d;
      chk_vld_q   <= chk_vld_d;
      chk_paddr_q <= chk_paddr_d;
      resp_vld_q  <= resp_vld_d;
      fault_q     <= fault_d;
    end
  end

  assign req_rdy_o         = req_rdy_q;
  assign chk_vld_o         = chk_vld_q;
  assign chk_paddr_o       = chk_paddr_q;
  assign chk_access_type_o = type_q;
  assign resp_vld_o        = resp_vld_q;
  assign resp_fault_o      = fault_q;
  assign resp_tag_o        = tag_q;

endmodule
